// File: rtl/aig_bist_sequencer.sv
// aig_bist_sequencer: self-test sequencer driving an N_IN-in/N_OUT-out AIG netlist and compacting its outputs into a 16-bit MISR.
// Ports: clk, rst (sync, active-high), start, abort, x_out (registered pattern), f_in (netlist outputs),
//   busy (APPLY/CAPTURE), done (DONE level), pat_idx (current pattern), signature (MISR).
// Optional macro AIG_BIST_GOLDEN_CMP_EN adds golden_sig input and pass output (signature == golden_sig on DONE entry).
module aig_bist_sequencer #(
  parameter int N_IN = 10,
  parameter int N_OUT = 10,
  parameter int PATTERN_COUNT = 1024,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [N_IN-1:0] PAT_SEED = '0,
  parameter logic [15:0] SIG_SEED = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  x_out,
  input  logic [N_OUT-1:0] f_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pat_idx,
  output logic [15:0]      signature
`ifdef AIG_BIST_GOLDEN_CMP_EN
  ,
  input  logic [15:0]      golden_sig,
  output logic             pass
`endif
);
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic [N_IN-1:0] x_n;
  logic [15:0] idx_n, sig_n, cnt, cnt_n, sig_upd;
  logic last;
`ifdef AIG_BIST_GOLDEN_CMP_EN
  logic pass_n;
`endif
  assign busy = (state == APPLY) || (state == CAPTURE);
  assign done = state == DONE;
  assign sig_upd = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ 16'(f_in);
  assign last = pat_idx == 16'(PATTERN_COUNT - 1);
  always_comb begin
    state_n = state;
    x_n = x_out;
    idx_n = pat_idx;
    sig_n = signature;
    cnt_n = cnt;
`ifdef AIG_BIST_GOLDEN_CMP_EN
    pass_n = pass;
`endif
    case (state)
      IDLE, DONE: if (start) begin
        state_n = APPLY;
        x_n = PAT_SEED;
        idx_n = '0;
        sig_n = SIG_SEED;
        cnt_n = '0;
`ifdef AIG_BIST_GOLDEN_CMP_EN
        pass_n = 1'b0;
`endif
      end
      APPLY: if (abort) begin
        state_n = IDLE;
        x_n = '0;
      end else begin
        cnt_n = cnt + 16'd1;
        state_n = (cnt == 16'(SETTLE_CYCLES - 1)) ? CAPTURE : APPLY;
      end
      CAPTURE: if (abort) begin
        state_n = IDLE;
        x_n = '0;
      end else if (last) begin
        state_n = DONE;
        x_n = '0;
        sig_n = sig_upd;
`ifdef AIG_BIST_GOLDEN_CMP_EN
        pass_n = sig_upd == golden_sig;
`endif
      end else begin
        state_n = APPLY;
        sig_n = sig_upd;
        idx_n = pat_idx + 16'd1;
        x_n = idx_n[N_IN-1:0] ^ PAT_SEED;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x_out <= '0;
      pat_idx <= '0;
      signature <= SIG_SEED;
      cnt <= '0;
`ifdef AIG_BIST_GOLDEN_CMP_EN
      pass <= 1'b0;
`endif
    end else begin
      state <= state_n;
      x_out <= x_n;
      pat_idx <= idx_n;
      signature <= sig_n;
      cnt <= cnt_n;
`ifdef AIG_BIST_GOLDEN_CMP_EN
      pass <= pass_n;
`endif
    end
  end
endmodule

// File: tb/tb_aig_bist_sequencer.sv
// tb_aig_bist_sequencer: directed scoreboard bench for aig_bist_sequencer across three parameterisations.
module tb_aig_bist_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start0 = 1'b0, abort0 = 1'b0, busy0, done0;
  logic [9:0] x0, f0 = '0;
  logic [15:0] idx0, sig0;
  logic start1 = 1'b0, abort1 = 1'b0, busy1, done1;
  logic [9:0] x1;
  logic [15:0] idx1, sig1;
  logic start2 = 1'b0, abort2 = 1'b0, busy2, done2;
  logic [9:0] x2, f2 = '0;
  logic [15:0] idx2, sig2;
`ifdef AIG_BIST_GOLDEN_CMP_EN
  logic [15:0] gold0 = '0, gold1 = '0, gold2 = '0;
  logic pass0, pass1, pass2;
`endif
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  aig_bist_sequencer #(.PATTERN_COUNT(4), .SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .x_out(x0), .f_in(f0),
    .busy(busy0), .done(done0), .pat_idx(idx0), .signature(sig0)
`ifdef AIG_BIST_GOLDEN_CMP_EN
    , .golden_sig(gold0), .pass(pass0)
`endif
  );
  aig_bist_sequencer #(.PATTERN_COUNT(2), .SETTLE_CYCLES(3), .PAT_SEED(10'h3FF)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .x_out(x1), .f_in(x1),
    .busy(busy1), .done(done1), .pat_idx(idx1), .signature(sig1)
`ifdef AIG_BIST_GOLDEN_CMP_EN
    , .golden_sig(gold1), .pass(pass1)
`endif
  );
  aig_bist_sequencer #(.PATTERN_COUNT(16), .SETTLE_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .x_out(x2), .f_in(f2),
    .busy(busy2), .done(done2), .pat_idx(idx2), .signature(sig2)
`ifdef AIG_BIST_GOLDEN_CMP_EN
    , .golden_sig(gold2), .pass(pass2)
`endif
  );
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] f);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ f;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_u0(input logic [9:0] f, input bit hold);
    logic [15:0] e;
    e = 16'h0000;
    start0 = 1'b1;
    tick();
    if (!hold) start0 = 1'b0;
    chk("u0_start_idx", idx0, 0);
    chk("u0_start_sig", sig0, 0);
    chk("u0_start_done", done0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("u0_apply_x", x0, k);
      chk("u0_apply_busy", busy0, 1);
      f0 = f;
      e = misr(e, 16'(f));
      exp_q.push_back(e);
      tick();
      chk("u0_capture_x", x0, k);
      chk("u0_capture_done", done0, 0);
      if (k == 3) start0 = 1'b0;
      tick();
      chk("u0_sig", sig0, exp_q.pop_front());
      chk("u0_idx", idx0, (k == 3) ? 3 : k + 1);
    end
    chk("u0_done", done0, 1);
    chk("u0_done_busy", busy0, 0);
    chk("u0_done_x", x0, 0);
  endtask
  initial begin
    logic [15:0] e;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_x", x0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_idx", idx0, 0);
    chk("rst_sig", sig0, 0);
`ifdef AIG_BIST_GOLDEN_CMP_EN
    chk("rst_pass", pass0, 0);
    gold0 = 16'h0001;
`endif
    run_u0(10'h000, 1'b0);
    chk("u0_runA_final", sig0, 16'h0000);
`ifdef AIG_BIST_GOLDEN_CMP_EN
    chk("u0_runA_pass", pass0, 0);
    gold0 = 16'h000F;
`endif
    repeat (3) tick();
    chk("u0_done_frozen_idx", idx0, 3);
    chk("u0_done_frozen_done", done0, 1);
    run_u0(10'h001, 1'b1);
    chk("u0_runB_final", sig0, 16'h000F);
`ifdef AIG_BIST_GOLDEN_CMP_EN
    chk("u0_runB_pass", pass0, 1);
`endif
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    f0 = 10'h2A5;
    repeat (7) tick();
    chk("u0_last_capture_busy", busy0, 1);
    chk("u0_last_capture_x", x0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("u0_midrst_busy", busy0, 0);
    chk("u0_midrst_done", done0, 0);
    chk("u0_midrst_x", x0, 0);
    chk("u0_midrst_idx", idx0, 0);
    chk("u0_midrst_sig", sig0, 0);
    tick();
    chk("u0_midrst_nodone", done0, 0);
    e = 16'h0000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) begin
        chk("u1_apply_x", x1, 10'h3FF ^ 10'(k));
        chk("u1_apply_busy", busy1, 1);
        tick();
      end
      e = misr(e, 16'(10'h3FF ^ 10'(k)));
      exp_q.push_back(e);
      chk("u1_capture_done", done1, 0);
      tick();
      chk("u1_sig", sig1, exp_q.pop_front());
    end
    chk("u1_final_sig", sig1, 16'h0400);
    chk("u1_done", done1, 1);
    chk("u1_idx", idx1, 1);
    e = 16'h0000;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      f2 = 10'(k * 37 + 5);
      e = misr(e, 16'(f2));
      exp_q.push_back(e);
      repeat (3) tick();
      tick();
      chk("u2_sig", sig2, exp_q.pop_front());
    end
    chk("u2_p5_x", x2, 5);
    tick();
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    chk("u2_abort_busy", busy2, 0);
    chk("u2_abort_done", done2, 0);
    chk("u2_abort_x", x2, 0);
    chk("u2_abort_idx", idx2, 5);
    chk("u2_abort_sig", sig2, e);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    chk("u2_idle_abort_idx", idx2, 5);
    chk("u2_idle_abort_sig", sig2, e);
    start2 = 1'b1;
    abort2 = 1'b1;
    tick();
    chk("u2_idle_start_wins", busy2, 1);
    chk("u2_restart_idx", idx2, 0);
    chk("u2_restart_sig", sig2, 0);
    tick();
    start2 = 1'b0;
    abort2 = 1'b0;
    chk("u2_busy_abort_wins", busy2, 0);
    chk("u2_busy_abort_done", done2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
